skolem_exhaustive_checker: RTL and testbench



---
 rtl/skolem_exhaustive_checker.sv | 175 +++++++++++++++++
 tb/tb_skolem_exhaustive_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skolem_exhaustive_checker.sv
// ============================================================================
// skolem_exhaustive_checker
// Enumerates every input vector of a Skolem candidate and compares it against
// a golden oracle, reporting pass/fail, mismatch count and first failing vector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module skolem_exhaustive_checker #(
  parameter int N_IN = 8,
  parameter int LAT  = 0,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  output logic            vec_valid,
  input  logic            cand_out,
  input  logic            gold_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0]    c_lat_m1  = (LAT > 0) ? 3'(LAT - 1) : 3'd0;
  localparam logic [CW-1:0] c_cnt_max = '1;

  state_t          r_state;
  logic [N_IN-1:0] r_vec;
  logic            r_vld;
  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_ffv;
  logic            r_ffvalid;
  logic [2:0]      r_drain;

  logic            w_active;
  logic            w_start_take;
  logic            w_abort_take;
  logic            w_flush;
  logic [N_IN-1:0] w_tag_vec;
  logic            w_tag_vld;
  logic            w_hit;

  assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_start_take = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_abort_take = abort && w_active;
  assign w_flush      = w_start_take || w_abort_take;
  assign w_hit        = w_active && w_tag_vld && (cand_out != gold_out);

  // Tag pipeline aligns each vector with the candidate/golden response LAT cycles later.
  generate
    if (LAT == 0) begin : g_nopipe
      assign w_tag_vec = r_vec;
      assign w_tag_vld = r_vld;
    end else begin : g_pipe
      logic [N_IN-1:0] r_pvec [LAT];
      logic            r_pvld [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) begin
            r_pvec[i] <= '0;
            r_pvld[i] <= 1'b0;
          end
        end else if (w_flush) begin
          for (int i = 0; i < LAT; i++) begin
            r_pvld[i] <= 1'b0;
          end
        end else begin
          r_pvec[0] <= r_vec;
          r_pvld[0] <= r_vld;
          for (int i = 1; i < LAT; i++) begin
            r_pvec[i] <= r_pvec[i-1];
            r_pvld[i] <= r_pvld[i-1];
          end
        end
      end

      assign w_tag_vec = r_pvec[LAT-1];
      assign w_tag_vld = r_pvld[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vec     <= '0;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_ffv     <= '0;
      r_ffvalid <= 1'b0;
      r_drain   <= 3'd0;
    end else begin
      if (w_hit) begin
        if (r_cnt != c_cnt_max) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (!r_ffvalid) begin
          r_ffv     <= w_tag_vec;
          r_ffvalid <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_vec     <= '0;
            r_vld     <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_ffv     <= '0;
            r_ffvalid <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (&r_vec) begin
            r_vld <= 1'b0;
            if (LAT == 0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
              r_drain <= c_lat_m1;
            end
          end else begin
            r_vec <= r_vec + 1'b1;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_drain == 3'd0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec_out          = r_vec;
  assign vec_valid        = r_vld;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_done && (r_cnt == '0);
  assign mismatch_cnt     = r_cnt;
  assign first_fail_vec   = r_ffv;
  assign first_fail_valid = r_ffvalid;

endmodule

`default_nettype wire

// File: tb/tb_skolem_exhaustive_checker.sv
// ============================================================================
// tb_skolem_exhaustive_checker
// Scoreboard bench: three checker instances (LAT=0/CW=16, LAT=2/CW=16, LAT=0/CW=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_skolem_exhaustive_checker;

  typedef struct {
    int cnt;
    int ffv;
    int ffval;
    int pass;
    int off;
    int s;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   mode  = 0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gold_f(input logic [7:0] v);
    return (^v) ^ (v[0] & v[7]);
  endfunction

  function automatic logic flt_a(input int m, input logic [7:0] v);
    return (m == 2) || (m == 1 && v == 8'h5A);
  endfunction

  function automatic logic flt_b(input int m, input logic [7:0] v);
    return (m == 2) || (m == 1 && (v == 8'h03 || v == 8'hF0));
  endfunction

  // instance 0: LAT=0, CW=16
  logic [7:0]  vo0, ffv0;
  logic        vv0, bz0, dn0, ps0, ffval0;
  logic [15:0] mc0;
  logic        cand0, gold0;
  assign gold0 = gold_f(vo0);
  assign cand0 = gold_f(vo0) ^ flt_a(mode, vo0);

  skolem_exhaustive_checker #(.N_IN(8), .LAT(0), .CW(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_out(vo0), .vec_valid(vv0), .cand_out(cand0), .gold_out(gold0),
    .busy(bz0), .done(dn0), .pass(ps0), .mismatch_cnt(mc0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0));

  // instance 1: LAT=2, both paths registered twice
  logic [7:0]  vo1, ffv1;
  logic        vv1, bz1, dn1, ps1, ffval1;
  logic [15:0] mc1;
  logic        ga, gb, ca, cb;
  always @(posedge clk) begin
    ga <= gold_f(vo1);
    ca <= gold_f(vo1) ^ flt_b(mode, vo1);
    gb <= ga;
    cb <= ca;
  end

  skolem_exhaustive_checker #(.N_IN(8), .LAT(2), .CW(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_out(vo1), .vec_valid(vv1), .cand_out(cb), .gold_out(gb),
    .busy(bz1), .done(dn1), .pass(ps1), .mismatch_cnt(mc1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1));

  // instance 2: LAT=0, CW=4
  logic [7:0]  vo2, ffv2;
  logic        vv2, bz2, dn2, ps2, ffval2;
  logic [3:0]  mc2;
  logic        cand2, gold2;
  assign gold2 = gold_f(vo2);
  assign cand2 = gold_f(vo2) ^ flt_a(mode, vo2);

  skolem_exhaustive_checker #(.N_IN(8), .LAT(0), .CW(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_out(vo2), .vec_valid(vv2), .cand_out(cand2), .gold_out(gold2),
    .busy(bz2), .done(dn2), .pass(ps2), .mismatch_cnt(mc2),
    .first_fail_vec(ffv2), .first_fail_valid(ffval2));

  logic        dn[3], bz[3], ps[3], ffval[3];
  logic [15:0] mc[3];
  logic [7:0]  ffv[3];
  always_comb begin
    dn[0] = dn0; bz[0] = bz0; ps[0] = ps0; ffval[0] = ffval0; mc[0] = mc0; ffv[0] = ffv0;
    dn[1] = dn1; bz[1] = bz1; ps[1] = ps1; ffval[1] = ffval1; mc[1] = mc1; ffv[1] = ffv1;
    dn[2] = dn2; bz[2] = bz2; ps[2] = ps2; ffval[2] = ffval2; mc[2] = {12'd0, mc2}; ffv[2] = ffv2;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Hand-computed results per instance and fault mode.
  function automatic exp_t exp_for(input int i, input int m, input int s);
    exp_t e;
    e.s     = s;
    e.off   = (i == 1) ? 258 : 256;
    e.cnt   = 0; e.ffv = 0; e.ffval = 0; e.pass = 1;
    if (m == 1) begin
      e.cnt   = (i == 1) ? 2 : 1;
      e.ffv   = (i == 1) ? 8'h03 : 8'h5A;
      e.ffval = 1; e.pass = 0;
    end else if (m == 2) begin
      e.cnt   = (i == 2) ? 15 : 256;
      e.ffv   = 0;
      e.ffval = 1; e.pass = 0;
    end
    return e;
  endfunction

  task automatic pop_q(input int i, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = exp_for(0, 0, 0);
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Monitor: on every rising done, pop the expectation and compare.
  int   bcnt[3] = '{0, 0, 0};
  logic pdn[3]  = '{1'b0, 1'b0, 1'b0};
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    for (int i = 0; i < 3; i++) begin
      if (dn[i] && !pdn[i]) begin
        pop_q(i, e, ok);
        if (!ok) begin
          chk($sformatf("u%0d_unexpected_done", i), 1, 0);
        end else begin
          chk($sformatf("u%0d_mismatch_cnt", i), mc[i], e.cnt);
          chk($sformatf("u%0d_first_fail_vec", i), ffv[i], e.ffv);
          chk($sformatf("u%0d_first_fail_valid", i), ffval[i], e.ffval);
          chk($sformatf("u%0d_pass", i), ps[i], e.pass);
          chk($sformatf("u%0d_done_cycle", i), cyc - e.s, e.off);
          chk($sformatf("u%0d_busy_cycles", i), bcnt[i], e.off);
        end
        bcnt[i] = 0;
      end else if (bz[i]) begin
        bcnt[i]++;
      end else if (!dn[i]) begin
        bcnt[i] = 0;
      end
      pdn[i] = dn[i];
    end
  end

  // Called at a negedge: pulse start for one edge and queue expectations.
  task automatic kick(input int m, input bit p0, input bit p1, input bit p2);
    int s;
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s = cyc;
    if (p0) q0.push_back(exp_for(0, m, s));
    if (p1) q1.push_back(exp_for(1, m, s));
    if (p2) q2.push_back(exp_for(2, m, s));
  endtask

  task automatic wait_done0();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (dn0) return;
    end
    chk("u0_done_timeout", 0, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vec_out"}, vo0, 0);
    chk({tag, "_vec_valid"}, vv0, 0);
    chk({tag, "_busy"}, bz0, 0);
    chk({tag, "_done"}, dn0, 0);
    chk({tag, "_pass"}, ps0, 0);
    chk({tag, "_mismatch_cnt"}, mc0, 0);
    chk({tag, "_first_fail_vec"}, ffv0, 0);
    chk({tag, "_first_fail_valid"}, ffval0, 0);
    chk({tag, "_u1_busy"}, bz1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    // clean run, all instances pass
    @(negedge clk);
    kick(0, 1, 1, 1);
    repeat (270) @(negedge clk);

    // single/double faults, start mid-run ignored, then back-to-back start
    kick(1, 1, 1, 1);
    repeat (119) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done0();
    kick(2, 1, 0, 1);
    chk("u1_ignores_start_in_drain", bz1, 1);
    chk("u0_done_drops_after_restart", dn0, 0);
    repeat (270) @(negedge clk);

    // all-inverted candidate on every instance (CW=4 saturates)
    kick(2, 1, 1, 1);
    repeat (270) @(negedge clk);

    // abort in cycle 100
    kick(0, 0, 0, 0);
    repeat (99) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", bz0, 0);
    chk("abort_done", dn0, 0);
    chk("abort_vec_valid", vv0, 0);
    chk("abort_pass", ps0, 0);
    chk("abort_u1_busy", bz1, 0);
    chk("abort_u1_vec_valid", vv1, 0);
    repeat (5) @(negedge clk);
    kick(0, 1, 1, 1);
    repeat (270) @(negedge clk);

    // asynchronous reset mid-run
    kick(2, 0, 0, 0);
    repeat (49) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_idle_busy", bz0, 0);
    chk("post_reset_idle_vec_valid", vv0, 0);
    chk("post_reset_idle_done", dn0, 0);
    kick(1, 1, 1, 1);
    repeat (270) @(negedge clk);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
